// File: rtl/coin_pair_unpacker.sv
// -----------------------------------------------------------------------------
// coin_pair_unpacker
//
// Receiving end of the coincidence output stream. Each valid-only pair word
// from the coincidence core is registered, buffered in a small FIFO and
// serialised into a framed 32-bit valid/ready stream for the readout path:
//   W0     = {SYNC_WORD, seq}
//   W1..W8 = pair[31:0] .. pair[255:224]  (LSB word first)
//   W9     = {16'h0000, pair[271:256]}    (pair index)
//   W10    = XOR of W0..W9                (only with COIN_PAIR_UNPACKER_CHECKSUM_EN)
// m_last marks the final word of each frame. Strobes that find the FIFO full
// are discarded and counted in drop_cnt (saturating).
//
// Optional feature macro: COIN_PAIR_UNPACKER_CHECKSUM_EN (adds the W10 checksum).
//
// Ports:
//   clk_200M             in   system clock
//   rst_n                in   asynchronous active-low reset
//   coincidence_data     in   pair word, sampled when coincidence_data_en=1
//   coincidence_data_en  in   single-cycle strobe, no backpressure
//   m_data               out  output stream word (registered)
//   m_valid              out  m_data is valid
//   m_ready              in   downstream accepts on m_valid & m_ready
//   m_last               out  final word of a frame
//   fifo_level           out  occupied FIFO entries
//   drop_cnt             out  pairs dropped on overflow, saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module coin_pair_unpacker #(
  parameter int          PAIR_DATA_WIDTH = 272,
  parameter int          FIFO_DEPTH      = 16,
  parameter int          FIFO_AW         = 4,
  parameter logic [15:0] SYNC_WORD       = 16'hA5C3
) (
  input  logic                       clk_200M,
  input  logic                       rst_n,
  input  logic [PAIR_DATA_WIDTH-1:0] coincidence_data,
  input  logic                       coincidence_data_en,
  output logic [31:0]                m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic [FIFO_AW:0]           fifo_level,
  output logic [15:0]                drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_CHK} state_t;

  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(FIFO_DEPTH);

  // Input capture stage: keeps the wide input bus off the FIFO write timing.
  logic                       r_in_en;
  logic [PAIR_DATA_WIDTH-1:0] r_in_data;

  // FIFO storage and pointers
  logic [PAIR_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]           r_level;
  logic [15:0]                r_drop;
  logic                       w_full, w_empty, w_wr, w_drop, w_pop;
  logic [PAIR_DATA_WIDTH-1:0] w_head;

  // Serialiser state
  state_t                     r_state, w_state_nxt;
  logic [PAIR_DATA_WIDTH-1:0] r_frame, w_frame_nxt;
  logic [3:0]                 r_idx, w_idx_nxt;
  logic [15:0]                r_seq, w_seq_nxt;
  logic [31:0]                r_data, w_data_nxt;
  logic                       r_valid, w_valid_nxt;
  logic                       r_last, w_last_nxt;
  logic                       w_hs, w_start, w_end;
`ifdef COIN_PAIR_UNPACKER_CHECKSUM_EN
  logic [31:0]                r_chk, w_chk_nxt;
`endif

  // Payload word k (1..9) of a frame.
  function automatic logic [31:0] word_sel(input logic [PAIR_DATA_WIDTH-1:0] f,
                                           input logic [3:0] k);
    logic [2:0] s;
    s = 3'(k - 4'd1);
    if (k == 4'd9) return {16'h0000, f[PAIR_DATA_WIDTH-1 -: 16]};
    else           return f[{s, 5'b00000} +: 32];
  endfunction

  assign w_full  = (r_level == DEPTH_L);
  assign w_empty = (r_level == '0);
  // A pop in the same cycle frees the slot the write lands in.
  assign w_wr    = r_in_en && (!w_full || w_pop);
  assign w_drop  = r_in_en && !w_wr;
  assign w_head  = r_mem[r_rd_ptr];
  assign w_hs    = r_valid && m_ready;

  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      r_in_en <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples pre-edge values regardless of statement order.
      r_in_en <= coincidence_data_en;
    end
  end

  // NOTE: data-path storage (input data, FIFO array, frame register) is not
  // reset; validity is carried by r_in_en / r_level / r_state, which are.
  always_ff @(posedge clk_200M) begin
    r_in_data <= coincidence_data;
    if (w_wr) r_mem[r_wr_ptr] <= r_in_data;
    if (w_pop) r_frame <= w_frame_nxt;
  end

  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end

  // Serialiser state register
  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_seq   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
`ifdef COIN_PAIR_UNPACKER_CHECKSUM_EN
      r_chk   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_seq   <= w_seq_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
`ifdef COIN_PAIR_UNPACKER_CHECKSUM_EN
      r_chk   <= w_chk_nxt;
`endif
    end
  end

  // Serialiser next-state and next-output logic
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path through
    // the case statement can infer a latch.
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_idx_nxt   = r_idx;
    w_seq_nxt   = r_seq;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_end       = 1'b0;
`ifdef COIN_PAIR_UNPACKER_CHECKSUM_EN
    // Running XOR of accepted words; W10 = XOR(W0..W8) ^ W9.
    w_chk_nxt   = w_hs ? (r_chk ^ r_data) : r_chk;
`endif

    unique case (r_state)
      S_IDLE: w_start = !w_empty;
      S_HDR: begin
        if (w_hs) begin
          w_data_nxt  = word_sel(r_frame, 4'd1);
          w_idx_nxt   = 4'd1;
          w_state_nxt = S_PAY;
        end
      end
      S_PAY: begin
        if (w_hs) begin
          if (r_idx == 4'd9) begin
`ifdef COIN_PAIR_UNPACKER_CHECKSUM_EN
            w_data_nxt  = r_chk ^ r_data;
            w_last_nxt  = 1'b1;
            w_state_nxt = S_CHK;
`else
            w_end = 1'b1;
`endif
          end else begin
            w_idx_nxt  = r_idx + 4'd1;
            w_data_nxt = word_sel(r_frame, r_idx + 4'd1);
`ifndef COIN_PAIR_UNPACKER_CHECKSUM_EN
            w_last_nxt = (r_idx == 4'd8);
`endif
          end
        end
      end
`ifdef COIN_PAIR_UNPACKER_CHECKSUM_EN
      S_CHK: w_end = w_hs;
`endif
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_end) begin
      w_seq_nxt   = r_seq + 16'd1;
      w_valid_nxt = 1'b0;
      w_last_nxt  = 1'b0;
      w_state_nxt = S_IDLE;
      w_start     = !w_empty;   // back-to-back frame, no bubble
    end

    if (w_start) begin
      w_pop       = 1'b1;
      w_frame_nxt = w_head;
      w_data_nxt  = {SYNC_WORD, w_seq_nxt};
      w_valid_nxt = 1'b1;
      w_last_nxt  = 1'b0;
      w_idx_nxt   = 4'd0;
      w_state_nxt = S_HDR;
`ifdef COIN_PAIR_UNPACKER_CHECKSUM_EN
      w_chk_nxt   = '0;
`endif
    end
  end

  assign m_data     = r_data;
  assign m_valid    = r_valid;
  assign m_last     = r_last;
  assign fifo_level = r_level;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_coin_pair_unpacker.sv
// -----------------------------------------------------------------------------
// tb_coin_pair_unpacker
//
// Directed bench for coin_pair_unpacker. Every accepted strobe pushes its
// expected frame words into a scoreboard queue; a negedge monitor pops and
// compares each handshaken word and checks that held words stay stable.
// Honours COIN_PAIR_UNPACKER_CHECKSUM_EN for the 11-word frame format.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_coin_pair_unpacker;

  localparam int PW    = 272;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef COIN_PAIR_UNPACKER_CHECKSUM_EN
  localparam int FW = 11;
`else
  localparam int FW = 10;
`endif

  logic          clk_200M = 1'b0;
  logic          rst_n    = 1'b0;
  logic [PW-1:0] coincidence_data = '0;
  logic          coincidence_data_en = 1'b0;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic [AW:0]   fifo_level;
  logic [15:0]   drop_cnt;

  coin_pair_unpacker #(
    .PAIR_DATA_WIDTH(PW), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW), .SYNC_WORD(16'hA5C3)
  ) dut (
    .clk_200M(clk_200M), .rst_n(rst_n),
    .coincidence_data(coincidence_data), .coincidence_data_en(coincidence_data_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  always #2.5 clk_200M = ~clk_200M;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] sb[$];          // {last, data}
  logic [15:0] seq_m = '0;
  bit          mon_en = 1'b0;
  logic        p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
  logic [31:0] p_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_200M);
    #1;
  endtask

  // Expected frame for pair p, using the bench's own sequence counter.
  task automatic push_frame(input logic [PW-1:0] p);
    logic [31:0] w;
    logic [31:0] x;
    x = '0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      w = {16'hA5C3, seq_m};
      else if (k == 9) w = {16'h0000, p[271:256]};
      else             w = p[32*(k-1) +: 32];
      x ^= w;
      sb.push_back({(k == 9) && (FW == 10), w});
    end
    if (FW == 11) sb.push_back({1'b1, x});
    seq_m++;
  endtask

  task automatic strobe(input logic [PW-1:0] p, input bit accepted);
    coincidence_data    = p;
    coincidence_data_en = 1'b1;
    if (accepted) push_frame(p);
    tick();
    coincidence_data_en = 1'b0;
  endtask

  function automatic logic [PW-1:0] mk_pair(input logic [15:0] index);
    logic [PW-1:0] p;
    for (int k = 0; k < 8; k++) p[32*k +: 32] = $urandom;
    p[271:256] = index;
    return p;
  endfunction

  task automatic drain(input string tag, input int budget);
    int c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard monitor and hold-stability checker
  always @(negedge clk_200M) begin
    if (mon_en) begin
      if (p_valid && !p_ready)
        check("hold", {m_valid, m_last, m_data}, {1'b1, p_last, p_data});
      if (m_valid && m_ready) begin
        if (sb.size() == 0) check("unexpected_word", {m_last, m_data}, 64'h1_DEAD_0000);
        else                check("word", {m_last, m_data}, sb.pop_front());
      end
      p_valid = m_valid;
      p_ready = m_ready;
      p_last  = m_last;
      p_data  = m_data;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] p1;
    bit            pat [4];
    int            peak, vcnt, gaps;
    bit            seen, was;

    // ---------------- reset state
    tick(); tick();
    check("rst_valid", m_valid, 0);
    check("rst_last",  m_last, 0);
    check("rst_data",  m_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drop",  drop_cnt, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // ---------------- single pair, latency and frame contents
    p1 = '0;
    p1[31:0]    = 32'h01234567;
    p1[63:32]   = 32'hDEADBEEF;
    for (int k = 2; k < 8; k++) p1[32*k +: 32] = 32'h1000_0000 + k;
    p1[271:256] = 16'h0007;
    m_ready = 1'b1;
    strobe(p1, 1'b1);                        // sampled at edge N
    check("lat_n0", m_valid, 0);
    tick();
    check("lat_n1", m_valid, 0);
    tick();
    check("lat_n2", m_valid, 1);             // W0 after edge N+2
    for (int i = 0; i < FW; i++) begin
      check("contig", m_valid, 1);
      if (i == 0) check("w0", m_data, 32'hA5C30000);
      if (i == 1) check("w1", m_data, 32'h01234567);
      if (i == 2) check("w2", m_data, 32'hDEADBEEF);
      if (i == 9) check("w9", {m_last, m_data}, {(FW == 10), 32'h00000007});
      if (i == FW - 1) check("last_final", m_last, 1);
      tick();
    end
    check("frame_end", m_valid, 0);
    check("sb_empty1", 64'(sb.size()), 0);

    // ---------------- three back-to-back strobes
    peak = 0; vcnt = 0; gaps = 0; seen = 0; was = 0;
    for (int s = 0; s < 3 + 40; s++) begin
      if (s < 3) strobe(mk_pair(16'(s + 1)), 1'b1);
      else       tick();
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (m_valid) begin
        if (seen && !was) gaps++;
        seen = 1;
        vcnt++;
      end
      was = m_valid;
    end
    check("b2b_valid_cycles", 64'(vcnt), 64'(3 * FW));
    check("b2b_gaps", 64'(gaps), 0);
    check("b2b_peak_level", 64'(peak), 2);
    check("sb_empty2", 64'(sb.size()), 0);

    // ---------------- backpressure 1,0,0,1
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    strobe(mk_pair(16'h0055), 1'b1);
    for (int c = 0; c < 200 && sb.size() != 0; c++) begin
      m_ready = pat[c % 4];
      tick();
    end
    m_ready = 1'b1;
    drain("bp_drain", 50);

    // ---------------- overflow with m_ready low
    m_ready = 1'b0;
    strobe(mk_pair(16'h0100), 1'b1);
    tick(); tick(); tick();                   // pair now held in the frame register
    check("ovf_inflight_valid", m_valid, 1);
    check("ovf_pre_level", fifo_level, 0);
    for (int i = 0; i < 20; i++) strobe(mk_pair(16'(16'h0200 + i)), i < DEPTH);
    tick();                                   // last strobe leaves the input stage
    check("ovf_level", fifo_level, 16);
    check("ovf_drop", drop_cnt, 4);
    m_ready = 1'b1;
    drain("ovf_drain_17_frames", 17 * FW + 50);
    check("ovf_level_after", fifo_level, 0);
    check("ovf_drop_hold", drop_cnt, 4);

    // ---------------- async reset during W4
    strobe(mk_pair(16'h0300), 1'b1);          // edge N
    strobe(mk_pair(16'h0301), 1'b1);          // edge N+1, stays queued
    repeat (5) tick();                        // after edge N+6: W4 presented
    check("pre_rst_valid", m_valid, 1);
    check("pre_rst_level", fifo_level, 1);
    mon_en  = 1'b0;
    p_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", m_valid, 0);
    check("midrst_last",  m_last, 0);
    check("midrst_data",  m_data, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_drop",  drop_cnt, 0);
    sb.delete();
    seq_m = '0;
    tick(); tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) tick();
    check("no_resume", m_valid, 0);
    strobe(mk_pair(16'h0400), 1'b1);
    tick(); tick();
    check("post_rst_hdr", {m_valid, m_data}, {1'b1, 32'hA5C30000});
    drain("post_rst_drain", 50);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
